// File: rtl/mem_stage.sv
// Unified instruction/data memory stage: word RAM with byte loads/stores,
// instruction register (IR) and memory data register (MDR).
module mem_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memread_i,
    input  logic          memwrite_i,
    input  logic          iord_i,
    input  logic          irwrite_i,
    input  logic [31:0]   pc_i,
    input  logic [31:0]   aluout_i,
    input  logic [31:0]   wdata_i,
    input  logic          load_en_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_data_i,
    output logic [31:0]   instr_o,
    output logic [5:0]    op_o,
    output logic [31:0]   mdr_o,
    output logic          err_o
);

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_instr;
    logic [31:0]   r_mdr;
    logic          r_err;

    logic [31:0]   w_addr;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_inRange;
    logic [31:0]   w_rdWord;
    logic [7:0]    w_byte;
    logic [31:0]   w_merged;
    logic          w_store;
    logic          w_fault;
    logic          w_unused;

    assign w_addr    = iord_i ? aluout_i : pc_i;
    assign w_idx     = w_addr[AW+1:2];
    assign w_lane    = w_addr[1:0];
    assign w_inRange = (w_addr[31:AW+2] == '0);
    assign w_rdWord  = w_inRange ? r_mem[w_idx] : 32'h0000_0000;
    assign w_byte    = w_rdWord[{w_lane, 3'b000} +: 8];
    assign w_store   = memwrite_i && iord_i && w_inRange;
    assign w_unused  = ^wdata_i[31:8];

    // Byte store rewrites the whole word with only the addressed lane replaced.
    always_comb begin
        w_merged = r_mem[w_idx];
        w_merged[{w_lane, 3'b000} +: 8] = wdata_i[7:0];
    end

    assign w_fault = (irwrite_i && !iord_i && (pc_i[1:0] != 2'b00))
                  || (!w_inRange && (memread_i || memwrite_i || irwrite_i))
                  || (memwrite_i && !iord_i);

    // RAM is never cleared; during reset only the preload port may write it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (load_en_i) begin
                r_mem[load_addr_i] <= load_data_i;
            end
        end else if (w_store) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= 32'h0000_0000;
            r_mdr   <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            if (irwrite_i) begin
                r_instr <= w_rdWord;
            end
            if (memread_i && iord_i) begin
                r_mdr <= {{24{w_byte[7]}}, w_byte};
            end
            if (w_fault) begin
                r_err <= 1'b1;
            end
        end
    end

    assign instr_o = r_instr;
    assign op_o    = r_instr[31:26];
    assign mdr_o   = r_mdr;
    assign err_o   = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, a behavioural memory
// model compared every cycle, and literal expectations from hand calculation.
module tb_mem_stage;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          memread_i, memwrite_i, iord_i, irwrite_i;
    logic [31:0]   pc_i, aluout_i, wdata_i;
    logic          load_en_i;
    logic [AW-1:0] load_addr_i;
    logic [31:0]   load_data_i;
    logic [31:0]   instr_o;
    logic [5:0]    op_o;
    logic [31:0]   mdr_o;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .memread_i(memread_i), .memwrite_i(memwrite_i),
        .iord_i(iord_i), .irwrite_i(irwrite_i),
        .pc_i(pc_i), .aluout_i(aluout_i), .wdata_i(wdata_i),
        .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
        .instr_o(instr_o), .op_o(op_o), .mdr_o(mdr_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [31:0] mMem [DEPTH];
    logic [31:0] mInstr, mMdr;
    logic        mErr;
    bit          started = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decode the byte address arithmetically and apply the edge's effects.
    always @(posedge clk) begin
        longint unsigned a;
        int              idx, lane;
        bit              inR;
        logic [31:0]     rdWord;
        int              b;
        a      = iord_i ? aluout_i : pc_i;
        inR    = (a < 4 * DEPTH);
        idx    = int'(a / 4) % DEPTH;
        lane   = int'(a % 4);
        rdWord = inR ? mMem[idx] : 32'h0;
        if (rst) begin
            if (load_en_i) mMem[load_addr_i] = load_data_i;
            mInstr = 0;
            mMdr   = 0;
            mErr   = 0;
        end else begin
            if (irwrite_i) mInstr = rdWord;
            if (memread_i && iord_i) begin
                b    = int'((rdWord / (32'd1 << (8 * lane))) % 256);
                mMdr = (b >= 128) ? 32'(b - 256) : 32'(b);
            end
            if (memwrite_i && iord_i && inR)
                mMem[idx] = (mMem[idx] & ~(32'hFF << (8 * lane)))
                          | (32'(wdata_i[7:0]) << (8 * lane));
            if ((irwrite_i && !iord_i && (pc_i % 4 != 0))
                || (!inR && (memread_i || memwrite_i || irwrite_i))
                || (memwrite_i && !iord_i))
                mErr = 1;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("cyc_instr", instr_o, mInstr);
            checkOutput("cyc_op", 32'(op_o), 32'(mInstr[31:26]));
            checkOutput("cyc_mdr", mdr_o, mMdr);
            checkOutput("cyc_err", 32'(err_o), 32'(mErr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic io,
                                 input logic irw, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] wd);
        memread_i  = rd;
        memwrite_i = wr;
        iord_i     = io;
        irwrite_i  = irw;
        pc_i       = pc;
        aluout_i   = alu;
        wdata_i    = wd;
        tick();
        memread_i  = 0;
        memwrite_i = 0;
        irwrite_i  = 0;
    endtask

    logic [31:0] lbAddr [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
    logic [31:0] lbExp  [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};

    initial begin
        rst = 1; memread_i = 0; memwrite_i = 0; iord_i = 0; irwrite_i = 0;
        pc_i = 0; aluout_i = 0; wdata_i = 0;
        load_en_i = 0; load_addr_i = 0; load_data_i = 0;

        // Preload every word so the model never holds unknowns.
        for (int i = 0; i < DEPTH; i++) begin
            load_en_i   = 1;
            load_addr_i = AW'(i);
            case (i)
                0:       load_data_i = 32'h20010005;
                1:       load_data_i = 32'h8C220004;
                4:       load_data_i = 32'h80FF7F01;
                default: load_data_i = 32'hDEAD0000 | 32'(i);
            endcase
            tick();
        end
        load_en_i = 0;
        checkOutput("rst_instr", instr_o, 32'h0);
        checkOutput("rst_op", 32'(op_o), 32'h0);
        checkOutput("rst_mdr", mdr_o, 32'h0);
        checkOutput("rst_err", 32'(err_o), 32'h0);
        rst = 0;
        tick();

        applyStimulus(1, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        checkOutput("fetch_instr", instr_o, 32'h20010005);
        checkOutput("fetch_op", 32'(op_o), 32'h08);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 0, 32'h0, lbAddr[i], 32'h0);
            checkOutput("lb_sext", mdr_o, lbExp[i]);
        end

        applyStimulus(0, 1, 1, 0, 32'h0, 32'h11, 32'h123456AB);
        applyStimulus(1, 0, 0, 1, 32'h10, 32'h0, 32'h0);
        checkOutput("sb_word", instr_o, 32'h80FFAB01);
        applyStimulus(1, 0, 1, 0, 32'h0, 32'h11, 32'h0);
        checkOutput("sb_lb", mdr_o, 32'hFFFFFFAB);

        applyStimulus(1, 1, 1, 0, 32'h0, 32'h10, 32'h000000C3);
        checkOutput("coll_old", mdr_o, 32'h00000001);
        applyStimulus(1, 0, 1, 0, 32'h0, 32'h10, 32'h0);
        checkOutput("coll_new", mdr_o, 32'hFFFFFFC3);
        checkOutput("no_err_yet", 32'(err_o), 32'h0);

        applyStimulus(1, 0, 0, 1, 32'h6, 32'h0, 32'h0);
        checkOutput("misalign_err", 32'(err_o), 32'h1);
        checkOutput("misalign_ir", instr_o, 32'h8C220004);

        rst = 1; tick(); rst = 0;
        checkOutput("err_cleared", 32'(err_o), 32'h0);
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h400, 32'h00000077);
        checkOutput("oor_err", 32'(err_o), 32'h1);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("err_sticky", 32'(err_o), 32'h1);
        applyStimulus(1, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        checkOutput("oor_noram", instr_o, 32'h20010005);

        rst = 1; tick(); rst = 0;
        applyStimulus(0, 1, 0, 0, 32'h10, 32'h0, 32'h000000EE);
        checkOutput("st_iord0_err", 32'(err_o), 32'h1);

        irwrite_i = 1; memread_i = 1; iord_i = 0; pc_i = 32'h10; rst = 1;
        tick();
        irwrite_i = 0; memread_i = 0;
        checkOutput("rst_mid_ir", instr_o, 32'h0);
        rst = 0;
        load_en_i = 1; load_addr_i = 8'd4; load_data_i = 32'hFFFFFFFF;
        tick();
        load_en_i = 0;
        applyStimulus(1, 0, 0, 1, 32'h10, 32'h0, 32'h0);
        checkOutput("load_ignored", instr_o, 32'h80FFABC3);
        applyStimulus(1, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        checkOutput("ram_kept", instr_o, 32'h20010005);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
